char_cmd_ctrl: RTL and testbench

Sequencer between the UART receiver and the text character buffer. It assembles the 3-byte serial command (column, row, ASCII code) into one buffer write at the linear cell address, with a ready/valid stall. It range-checks coordinates and resynchronises framing after an inter-byte timeout. It sits in top between the UART RX byte output and the character RAM write port, which is shared with the VGA fetch.

---
 rtl/vga_text_pkg.sv | 18 +
 rtl/char_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_char_cmd_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared text-mode geometry, command sequencer state encoding and clear opcode.
package vga_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CLEAR_OP = 8'hFF;

  typedef enum logic [2:0] {
    S_COL   = 3'd0,
    S_ROW   = 3'd1,
    S_CHAR  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/char_cmd_ctrl.sv
// Assembles (col, row, char) UART bytes into one character-buffer write with a ready/valid stall.
// Optional screen clear (column byte 0xFF) enabled by defining CHAR_CMD_CLEAR_EN.
module char_cmd_ctrl #(
  parameter int COLS        = vga_text_pkg::COLS,
  parameter int ROWS        = vga_text_pkg::ROWS,
  parameter int ADDR_W      = vga_text_pkg::ADDR_W,
  parameter int TIMEOUT_CYC = 4340
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  input  logic              wr_ready_i,
  output logic              err_o,
  output logic              busy_o
);

  import vga_text_pkg::*;

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC);
  localparam logic [7:0]      COL_LIM  = 8'(COLS);
  localparam logic [7:0]      ROW_LIM  = 8'(ROWS);
`ifdef CHAR_CMD_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
`endif

  state_t        state;
  logic [7:0]    col_q;
  logic [7:0]    row_q;
  logic [7:0]    pend_q;
  logic          pend_vld;
  logic [TW-1:0] tmo_cnt;
  logic          wr_done;

  // Constant multiply by COLS as a sum of shifted row copies.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] row, input logic [7:0] col);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int i = 0; i < 32; i++) begin
      if (COLS[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

  // Last handshake of the current write burst (single write, or final clear cell).
  always_comb begin
`ifdef CHAR_CMD_CLEAR_EN
    wr_done = wr_en_o && wr_ready_i && ((state == S_WRITE) || (wr_addr_o == LAST_ADDR));
`else
    wr_done = wr_en_o && wr_ready_i;
`endif
  end

  assign busy_o = (state != S_COL) || pend_vld;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_COL;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      err_o     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      pend_q    <= '0;
      pend_vld  <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      err_o <= 1'b0;
      if (rx_valid_i)
        tmo_cnt <= '0;
      else if (((state == S_ROW) || (state == S_CHAR)) && (tmo_cnt != TMO_LAST))
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        S_COL: begin
          if (rx_valid_i) begin
            col_q <= rx_data_i;
            state <= S_ROW;
          end
        end

        S_ROW: begin
          if (rx_valid_i) begin
            row_q <= rx_data_i;
            state <= S_CHAR;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o   <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_COL;
          end
        end

        S_CHAR: begin
          if (rx_valid_i) begin
`ifdef CHAR_CMD_CLEAR_EN
            if (col_q == CLEAR_OP) begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= '0;
              wr_data_o <= rx_data_i;
              state     <= S_CLEAR;
            end else
`endif
            if ((col_q >= COL_LIM) || (row_q >= ROW_LIM)) begin
              err_o <= 1'b1;
              state <= S_COL;
            end else begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= cell_addr(row_q, col_q);
              wr_data_o <= rx_data_i;
              state     <= S_WRITE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_o   <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_COL;
          end
        end

        S_WRITE, S_CLEAR: begin
          if (rx_valid_i && pend_vld) err_o <= 1'b1;
          if (wr_done) begin
            // Held or coincident byte becomes the next column immediately.
            wr_en_o <= 1'b0;
            if (pend_vld) begin
              col_q    <= pend_q;
              pend_vld <= 1'b0;
              state    <= S_ROW;
            end else if (rx_valid_i) begin
              col_q <= rx_data_i;
              state <= S_ROW;
            end else begin
              state <= S_COL;
            end
          end else begin
`ifdef CHAR_CMD_CLEAR_EN
            if (wr_en_o && wr_ready_i) wr_addr_o <= wr_addr_o + 1'b1;
`endif
            if (rx_valid_i && !pend_vld) begin
              pend_q   <= rx_data_i;
              pend_vld <= 1'b1;
            end
          end
        end

        default: state <= S_COL;
      endcase
    end
  end

endmodule

// File: tb/tb_char_cmd_ctrl.sv
// Randomized and directed bench for char_cmd_ctrl against a command-level reference model.
module tb_char_cmd_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int TMO   = 4340;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          wr_ready = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          err;
  logic          busy;

  char_cmd_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_ready_i(wr_ready),
    .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial command bytes, active write, one-entry holding queue.
  int m_cmd[$];
  int m_pend[$];
  int m_idle;
  bit m_wr, m_clr, m_err;
  int m_addr, m_data;

  // Observed traffic.
  int n_wr = 0, n_err = 0, last_a = 0, last_d = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd.delete(); m_pend.delete();
    m_idle = 0; m_wr = 0; m_clr = 0; m_err = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit rdy);
    m_err = 0;
    if (m_wr) begin
      if (v) begin
        if (m_pend.size() == 0) m_pend.push_back(d);
        else m_err = 1;
      end
      if (rdy) begin
        if (m_clr && m_addr < CELLS - 1) m_addr++;
        else begin
          m_wr = 0; m_clr = 0;
          if (m_pend.size() > 0) begin
            m_cmd.push_back(m_pend.pop_front());
            m_idle = 0;
          end
        end
      end
    end else if (v) begin
      m_cmd.push_back(d);
      m_idle = 0;
      if (m_cmd.size() == 3) begin
`ifdef CHAR_CMD_CLEAR_EN
        if (m_cmd[0] == 255) begin
          m_wr = 1; m_clr = 1; m_addr = 0; m_data = m_cmd[2];
        end else
`endif
        if (m_cmd[0] >= COLS || m_cmd[1] >= ROWS) m_err = 1;
        else begin
          m_wr = 1; m_addr = m_cmd[1] * COLS + m_cmd[0]; m_data = m_cmd[2];
        end
        m_cmd.delete();
      end
    end else if (m_cmd.size() > 0) begin
      m_idle++;
      if (m_idle > TMO) begin
        m_err = 1;
        m_cmd.delete();
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    bit exp_busy;
    rx_valid = v; rx_data = d; wr_ready = rdy;
    if (!rst && wr_en === 1'b1 && rdy) begin
      n_wr++; last_a = int'(wr_addr); last_d = int'(wr_data);
    end
    @(posedge clk);
    if (rst) model_reset();
    else model_step(v, int'(d), rdy);
    #1;
    exp_busy = m_wr || (m_cmd.size() > 0) || (m_pend.size() > 0);
    check_val("wr_en", wr_en, m_wr);
    if (m_wr) begin
      check_val("wr_addr", wr_addr, m_addr);
      check_val("wr_data", wr_data, m_data);
    end
    check_val("err", err, m_err);
    check_val("busy", busy, exp_busy);
    if (err === 1'b1) n_err++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic send3(input int c, input int r, input int ch, input int gap);
    cycle(1'b1, 8'(c), 1'b1); idle(gap, 1'b1);
    cycle(1'b1, 8'(r), 1'b1); idle(gap, 1'b1);
    cycle(1'b1, 8'(ch), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, e0;
    model_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check_val("rst_addr", wr_addr, 0);
    check_val("rst_data", wr_data, 0);
    rst = 1'b0;
    idle(2, 1'b1);

    // Basic writes
    w0 = n_wr; e0 = n_err;
    send3(17, 29, 8'h32, 3); idle(3, 1'b1);
    check_val("w1_count", n_wr - w0, 1);
    check_val("w1_addr", last_a, 2337);
    check_val("w1_data", last_d, 8'h32);
    check_val("w1_err", n_err - e0, 0);
    send3(79, 0, 8'h39, 0); idle(2, 1'b1);
    check_val("w2_addr", last_a, 79);
    check_val("w2_data", last_d, 8'h39);
    send3(0, 0, 8'h41, 1); idle(2, 1'b1);
    check_val("w3_addr", last_a, 0);
    check_val("w3_data", last_d, 8'h41);

    // Range errors
    w0 = n_wr; e0 = n_err;
    send3(80, 5, 8'h41, 0); idle(2, 1'b1);
    send3(3, 30, 8'h41, 0); idle(2, 1'b1);
    check_val("range_err", n_err - e0, 2);
    check_val("range_nowr", n_wr - w0, 0);
    send3(1, 1, 8'h42, 0); idle(2, 1'b1);
    check_val("after_range_addr", last_a, 81);

    // Timeout discards partial command
    e0 = n_err;
    cycle(1'b1, 8'd10, 1'b1); cycle(1'b1, 8'd2, 1'b1);
    idle(TMO + 1, 1'b1);
    check_val("tmo_err", n_err - e0, 1);
    check_val("tmo_busy", busy, 0);
    send3(5, 1, 8'h43, 0); idle(2, 1'b1);
    check_val("tmo_next_addr", last_a, 85);
    check_val("tmo_next_data", last_d, 8'h43);

    // Byte arriving exactly on the timeout cycle wins
    w0 = n_wr; e0 = n_err;
    cycle(1'b1, 8'd10, 1'b1); cycle(1'b1, 8'd2, 1'b1);
    idle(TMO, 1'b1);
    cycle(1'b1, 8'h44, 1'b1); idle(2, 1'b1);
    check_val("tmo_edge_err", n_err - e0, 0);
    check_val("tmo_edge_addr", last_a, 170);
    check_val("tmo_edge_count", n_wr - w0, 1);

    // Stall with one held byte
    w0 = n_wr;
    cycle(1'b1, 8'd17, 1'b1); cycle(1'b1, 8'd29, 1'b1); cycle(1'b1, 8'h32, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(i == 2, 8'd5, 1'b0);
      check_val("stall_addr", wr_addr, 2337);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check_val("stall_acc_addr", last_a, 2337);
    cycle(1'b1, 8'd6, 1'b1); cycle(1'b1, 8'h47, 1'b1); idle(2, 1'b1);
    check_val("pend_count", n_wr - w0, 2);
    check_val("pend_addr", last_a, 485);
    check_val("pend_data", last_d, 8'h47);

    // Holding-register overflow
    e0 = n_err;
    cycle(1'b1, 8'd1, 1'b1); cycle(1'b1, 8'd2, 1'b1); cycle(1'b1, 8'h30, 1'b0);
    cycle(1'b1, 8'd9, 1'b0); cycle(1'b1, 8'd10, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'd1, 1'b1); cycle(1'b1, 8'h31, 1'b1); idle(2, 1'b1);
    check_val("ovf_err", n_err - e0, 1);
    check_val("ovf_addr", last_a, 89);

    // Reset in the middle of a stalled write
    w0 = n_wr;
    cycle(1'b1, 8'd1, 1'b1); cycle(1'b1, 8'd1, 1'b1); cycle(1'b1, 8'h42, 1'b0);
    idle(3, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check_val("rst_stall_en", wr_en, 0);
    idle(3, 1'b1);
    check_val("rst_stall_nowr", n_wr - w0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, rdy;
      logic [7:0] d;
      v   = ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom_range(0, 85));
      rdy = ($urandom_range(0, 3) != 0);
      cycle(v, d, rdy);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);
    rst = 1'b1; cycle(1'b0, 8'h00, 1'b1); rst = 1'b0;

    // Clear opcode
    w0 = n_wr; e0 = n_err;
    send3(8'hFF, 8'h00, 8'h20, 0);
`ifdef CHAR_CMD_CLEAR_EN
    for (int i = 0; i < 4000 && busy; i++) cycle(1'b0, 8'h00, $urandom_range(0, 3) != 0);
    check_val("clr_done", busy, 0);
    check_val("clr_count", n_wr - w0, CELLS);
    check_val("clr_last_addr", last_a, CELLS - 1);
    check_val("clr_data", last_d, 8'h20);
    check_val("clr_err", n_err - e0, 0);
`else
    idle(2, 1'b1);
    check_val("ff_err", n_err - e0, 1);
    check_val("ff_nowr", n_wr - w0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
